arm_boot_loader: RTL and testbench

//  Boot sequencer between a program word stream, arm_memory's data port and arm_core.

---
 rtl/arm_boot_loader_if.sv | 41 ++++
 rtl/arm_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_arm_boot_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_boot_loader_if.sv
// +------------------------------------------------------------------+
// | arm_boot_loader_if: program stream, core and memory-port signals |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface arm_boot_loader_if;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [31:0] core_mem_addr;
  logic [31:0] core_mem_data_in;
  logic        core_mem_write_en;
  logic        core_halted;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_en;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  modport slave (
    input  start, ld_valid, ld_data, ld_last,
    input  core_mem_addr, core_mem_data_in, core_mem_write_en, core_halted,
    output ld_ready, mem_addr, mem_data_in, mem_write_en,
    output core_rst, busy, done, error, word_count
  );

  modport master (
    output start, ld_valid, ld_data, ld_last,
    output core_mem_addr, core_mem_data_in, core_mem_write_en, core_halted,
    input  ld_ready, mem_addr, mem_data_in, mem_write_en,
    input  core_rst, busy, done, error, word_count
  );
endinterface

`default_nettype wire

// File: rtl/arm_boot_loader.sv
// +------------------------------------------------------------------+
// | arm_boot_loader: loads a program into memory, then runs the core |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module arm_boot_loader #(
  parameter logic [31:0] LOAD_BASE   = 32'h0,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned RST_HOLD    = 2,
  parameter int unsigned HALT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  arm_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [15:0] C_LAST_IDX  = 16'(MAX_WORDS - 1);
  localparam logic [15:0] C_HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [15:0] C_HALT_LAST = 16'(HALT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        core_rst_q, core_rst_d;
  logic        fin_q, fin_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= LOAD_BASE;
      wc_q       <= 16'd0;
      cnt_q      <= 16'd0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      core_rst_q <= 1'b1;
      fin_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wc_q       <= wc_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      core_rst_q <= core_rst_d;
      fin_q      <= fin_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    fin_d   = fin_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LOAD;
          ptr_d   = LOAD_BASE;
          wc_d    = 16'd0;
          ready_d = 1'b1;
          fin_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // fin/ovf mark the cycle in which the final write is on the port
        if (fin_q) begin
          state_d = S_HOLD;
          cnt_d   = 16'd0;
          fin_d   = 1'b0;
        end else if (ovf_q) begin
          state_d = S_ERR;
        end else if (ready_q && bus.ld_valid) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = bus.ld_data;
          ptr_d  = ptr_q + 32'd4;
          wc_d   = wc_q + 16'd1;
          if (bus.ld_last) begin
            ready_d = 1'b0;
            fin_d   = 1'b1;
          end else if (wc_q == C_LAST_IDX) begin
            ready_d = 1'b0;
            ovf_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == C_HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (bus.core_halted) begin
          if (cnt_q == C_HALT_LAST) begin
            state_d = S_DONE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase

    core_rst_d = (state_d != S_RUN);
  end

  // The core owns the memory port combinationally only while running
  assign bus.mem_addr     = (state_q == S_RUN) ? bus.core_mem_addr     : addr_q;
  assign bus.mem_data_in  = (state_q == S_RUN) ? bus.core_mem_data_in  : data_q;
  assign bus.mem_write_en = (state_q == S_RUN) ? bus.core_mem_write_en : we_q;

  assign bus.ld_ready   = ready_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERR);
  assign bus.word_count = wc_q;

endmodule

`default_nettype wire

// File: tb/tb_arm_boot_loader.sv
// +------------------------------------------------------------------+
// | tb_arm_boot_loader: randomized self-checking bench               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_arm_boot_loader;
  localparam logic [31:0] LOAD_BASE   = 32'h0;
  localparam int          MAX_WORDS   = 4;
  localparam int          RST_HOLD    = 2;
  localparam int          HALT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] words [8];
  int   loaded_wc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_boot_loader_if bus ();

  arm_boot_loader #(
    .LOAD_BASE  (LOAD_BASE),
    .MAX_WORDS  (MAX_WORDS),
    .RST_HOLD   (RST_HOLD),
    .HALT_CYCLES(HALT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap_of(input int gmode);
    if (gmode == 1) return 2;
    if (gmode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic drive_core(input bit fixed);
    if (fixed) begin
      bus.core_mem_addr     = 32'h100;
      bus.core_mem_data_in  = 32'hDEADBEEF;
      bus.core_mem_write_en = 1'b1;
    end else begin
      bus.core_mem_addr     = $urandom;
      bus.core_mem_data_in  = $urandom;
      bus.core_mem_write_en = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk_passthrough();
    chk("run_addr", bus.mem_addr, bus.core_mem_addr);
    chk("run_data", bus.mem_data_in, bus.core_mem_data_in);
    chk("run_we", 32'(bus.mem_write_en), 32'(bus.core_mem_write_en));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'd1);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.mem_write_en), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_data"}, bus.mem_data_in, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
    chk({tag, "_wc"}, 32'(bus.word_count), 32'd0);
  endtask

  // Model: beat k is accepted on the k-th offered cycle while fewer than exp_n
  // beats are in; each write appears one cycle later at LOAD_BASE+4k.
  task automatic run_load(input int n, input int last_at, input int gmode, output bit legal);
    int  exp_n, nacc, k, gap, last_acc;
    bit  in_run, in_err, ended, wexp;
    legal = (last_at >= 0) && (last_at < MAX_WORDS);
    exp_n = legal ? last_at + 1 : MAX_WORDS;
    bus.core_halted = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    nacc = 0; k = 0; last_acc = -10; ended = 1'b0;
    gap = (gmode == 2) ? gap_of(gmode) : 0;
    for (int t = 0; t < 100; t++) begin
      drive_core(1'b0);
      #1;
      in_run = legal && (nacc == exp_n) && (cyc >= last_acc + RST_HOLD + 2);
      in_err = !legal && (nacc == exp_n) && (cyc >= last_acc + 2);
      chk("ld_ready", 32'(bus.ld_ready), 32'(nacc < exp_n));
      chk("word_count", 32'(bus.word_count), 32'(nacc));
      chk("core_rst", 32'(bus.core_rst), 32'(!in_run));
      chk("busy", 32'(bus.busy), 32'(!in_err));
      chk("error", 32'(bus.error), 32'(in_err));
      chk("done", 32'(bus.done), 32'd0);
      if (in_run) chk_passthrough();
      else begin
        wexp = (last_acc == cyc - 1);
        chk("load_we", 32'(bus.mem_write_en), 32'(wexp));
        if (wexp) begin
          chk("load_addr", bus.mem_addr, LOAD_BASE + 32'(4 * (nacc - 1)));
          chk("load_data", bus.mem_data_in, words[nacc - 1]);
        end
      end
      if ((in_run && cyc >= last_acc + RST_HOLD + 3) || (in_err && cyc >= last_acc + 3)) begin
        ended = 1'b1;
        break;
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      bus.ld_data  = $urandom;
      if (k < n) begin
        if (gap > 0) gap--;
        else begin
          bus.ld_valid = 1'b1;
          bus.ld_data  = words[k];
          bus.ld_last  = (k == last_at);
          if (nacc < exp_n) begin
            last_acc = cyc;
            nacc++;
            k++;
            gap = gap_of(gmode);
          end
        end
      end
      tick();
    end
    if (!ended) chk("load_timeout", 32'd0, 32'd1);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    loaded_wc = exp_n;
  endtask

  // Model: DONE follows the cycle in which HALT_CYCLES consecutive halts complete.
  task automatic run_phase(input bit directed);
    int run_len, done_cyc;
    bit done_exp, h;
    run_len = 0; done_exp = 1'b0; done_cyc = 0;
    for (int t = 0; t < 80; t++) begin
      drive_core(directed && t == 0);
      #1;
      if (!done_exp) begin
        chk_passthrough();
        chk("run_core_rst", 32'(bus.core_rst), 32'd0);
        chk("run_busy", 32'(bus.busy), 32'd1);
        chk("run_done", 32'(bus.done), 32'd0);
      end else begin
        chk("done_flag", 32'(bus.done), 32'd1);
        chk("done_core_rst", 32'(bus.core_rst), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_we", 32'(bus.mem_write_en), 32'd0);
        chk("done_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("done_wc", 32'(bus.word_count), 32'(loaded_wc));
        done_cyc++;
        if (done_cyc == 2) break;
      end
      if (!done_exp) begin
        if (directed && t < 2) h = (t == 0);
        else if (t >= 30) h = 1'b1;
        else h = ($urandom_range(0, 2) == 0);
        bus.core_halted = h;
        bus.start = (directed && t == 1) || ($urandom_range(0, 3) == 0);
        run_len = h ? run_len + 1 : 0;
        if (run_len == HALT_CYCLES) done_exp = 1'b1;
      end else begin
        bus.core_halted = 1'b0;
        bus.start = 1'b0;
      end
      tick();
      bus.start = 1'b0;
    end
    if (done_cyc != 2) chk("run_timeout", 32'd0, 32'd1);
    bus.core_halted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit legal;
    int n, last_at;
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 32'd0; bus.ld_last = 1'b0;
    bus.core_mem_addr = 32'd0; bus.core_mem_data_in = 32'd0;
    bus.core_mem_write_en = 1'b0; bus.core_halted = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    words[0] = 32'hE3A00001; words[1] = 32'hE3A01002; words[2] = 32'hE0802001;
    run_load(3, 2, 0, legal);
    run_phase(1'b1);
    run_load(3, 2, 1, legal);
    run_phase(1'b0);

    for (int i = 0; i < 8; i++) words[i] = $urandom;
    run_load(5, -1, 0, legal);
    run_load(4, 3, 0, legal);
    run_phase(1'b0);

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      n = int'($urandom_range(1, MAX_WORDS + 2));
      if (n <= MAX_WORDS && $urandom_range(0, 2) != 0) last_at = n - 1;
      else begin
        n = int'($urandom_range(MAX_WORDS, MAX_WORDS + 2));
        last_at = (n > MAX_WORDS && $urandom_range(0, 1) == 1) ? MAX_WORDS : -1;
      end
      run_load(n, last_at, 2, legal);
      if (legal) run_phase(1'b0);
    end

    // Reset in the middle of a load
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'h11111111; tick();
    bus.ld_data = 32'h22222222; tick();
    bus.ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("postrst");
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    run_load(3, 2, 2, legal);
    run_phase(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
